// File: rtl/iv_pkg.sv
// Shared definitions for the button encoder: color FSM states, debounce counter
// sizing and one-hot helpers used by the encoder logic.
package iv_pkg;

   localparam int unsigned DB_CNT_W = 20;

   typedef logic [DB_CNT_W-1:0] db_cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_HELD,
      ST_REL_WAIT
   } btn_state_e;

   function automatic logic [1:0] encode_onehot(input logic [3:0] v);
      logic [1:0] code;
      code = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) code = 2'(i);
      end
      return code;
   endfunction

   function automatic logic [3:0] decode_code(input logic [1:0] c);
      return 4'b0001 << c;
   endfunction

endpackage

// File: rtl/button_encoder_if.sv
// Raw button inputs and the debounced game-controller outputs of the encoder.
// master = encoder side, slave = the side driving buttons / consuming codes.
interface button_encoder_if;

   logic [3:0] BTN_RAW;
   logic       START_RAW;
   logic [1:0] BTN_CODE;
   logic       BTN_VALID;
   logic       START_GAME;

   modport master (
      input  BTN_RAW,
      input  START_RAW,
      output BTN_CODE,
      output BTN_VALID,
      output START_GAME
   );

   modport slave (
      output BTN_RAW,
      output START_RAW,
      input  BTN_CODE,
      input  BTN_VALID,
      input  START_GAME
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; the output is the second stage.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/button_encoder.sv
// Debounces four color buttons into a held-button code/valid pair and the start
// button into a level, each with a DB_CYCLES window after a 2-flop synchronizer.
module button_encoder
   import iv_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 20000
) (
   input  logic                CLK,
   input  logic                RST_N,
   button_encoder_if.master    bus
);

   localparam db_cnt_t DB_LAST = db_cnt_t'(DB_CYCLES - 1);
   localparam db_cnt_t DB_FULL = db_cnt_t'(DB_CYCLES);
   localparam db_cnt_t CNT_ONE = db_cnt_t'(1);

   logic [4:0] sync_w;
   logic [3:0] btn_sync;
   logic       start_sync;

   btn_state_e state_q;
   db_cnt_t    cnt_q;
   logic [1:0] cand_q;
   logic [1:0] code_q;
   logic       valid_q;
   logic       cand_match;
   logic       cand_low;

   logic       start_q;
   logic       start_d;
   db_cnt_t    start_cnt_q;
   db_cnt_t    start_cnt_d;

   sync_2ff #(.WIDTH(5)) u_sync (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .d_i    ({bus.START_RAW, bus.BTN_RAW}),
      .q_o    (sync_w)
   );

   assign btn_sync   = sync_w[3:0];
   assign start_sync = sync_w[4];

   assign cand_match = (btn_sync == decode_code(cand_q));
   assign cand_low   = ~btn_sync[cand_q];

   // Color FSM: qualify a single-hot press, then qualify its release; other
   // buttons are ignored once a color is held.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cand_q  <= 2'd0;
         code_q  <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if ($onehot(btn_sync)) begin
                  cand_q  <= encode_onehot(btn_sync);
                  cnt_q   <= '0;
                  state_q <= ST_PRESS_WAIT;
               end
            end
            ST_PRESS_WAIT: begin
               if (cand_match) begin
                  if (cnt_q == DB_LAST) begin
                     valid_q <= 1'b1;
                     code_q  <= cand_q;
                     state_q <= ST_HELD;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end else begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end
            end
            ST_HELD: begin
               if (cand_low) begin
                  cnt_q   <= '0;
                  state_q <= ST_REL_WAIT;
               end
            end
            ST_REL_WAIT: begin
               if (cand_low) begin
                  if (cnt_q == DB_LAST) begin
                     valid_q <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end else begin
                  cnt_q   <= '0;
                  state_q <= ST_HELD;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Start toggles on the DB_CYCLES+1-th disagreeing sample so its latency
   // matches the color path, which spends one extra edge latching in IDLE.
   always_comb begin
      start_d     = start_q;
      start_cnt_d = '0;
      if (start_sync != start_q) begin
         if (start_cnt_q == DB_FULL) begin
            start_d = ~start_q;
         end else begin
            start_cnt_d = start_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         start_q     <= 1'b0;
         start_cnt_q <= '0;
      end else begin
         start_q     <= start_d;
         start_cnt_q <= start_cnt_d;
      end
   end

   assign bus.BTN_CODE   = code_q;
   assign bus.BTN_VALID  = valid_q;
   assign bus.START_GAME = start_q;

endmodule

// File: tb/tb_button_encoder.sv
// Directed bench for button_encoder with DB_CYCLES=4: a timestamp-based model
// checked every cycle, plus literal edge-latency expectations.
module tb_button_encoder;

   localparam int DB = 4;

   logic CLK   = 1'b0;
   logic RST_N = 1'b1;

   button_encoder_if bus();

   button_encoder #(.DB_CYCLES(DB)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Model state: raw samples delayed two edges give what the debouncers see.
   int         tick = 0;
   logic [4:0] rh1 = '0;
   logic [4:0] rh2 = '0;
   logic [3:0] vis_b;
   logic       vis_s;
   logic       m_valid = 1'b0;
   logic [1:0] m_code  = 2'd0;
   logic       m_start = 1'b0;
   int         pend = -1;
   int         pend_since = 0;
   int         rel_since = -1;
   int         streak = 0;

   function automatic int bit_index(input logic [3:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic logic [3:0] one_hot(input int p);
      logic [3:0] r;
      r = 4'b0001 << p;
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) begin
            rh1 = '0; rh2 = '0;
            m_valid = 1'b0; m_code = 2'd0; m_start = 1'b0;
            pend = -1; rel_since = -1; streak = 0;
         end else begin
            tick++;
            vis_b = rh2[3:0];
            vis_s = rh2[4];
            rh2   = rh1;
            rh1   = {bus.START_RAW, bus.BTN_RAW};
            if (!m_valid) begin
               if (pend < 0) begin
                  if ($countones(vis_b) == 1) begin
                     pend = bit_index(vis_b);
                     pend_since = tick;
                  end
               end else if (vis_b != one_hot(pend)) begin
                  pend = -1;
               end else if (tick - pend_since == DB) begin
                  m_valid = 1'b1;
                  m_code  = 2'(pend);
                  pend    = -1;
               end
            end else begin
               if (vis_b[m_code]) rel_since = -1;
               else if (rel_since < 0) rel_since = tick;
               else if (tick - rel_since == DB) begin
                  m_valid   = 1'b0;
                  rel_since = -1;
               end
            end
            if (vis_s != m_start) streak++;
            else streak = 0;
            if (streak == DB + 1) begin
               m_start = ~m_start;
               streak  = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         checks++;
         if ({bus.BTN_CODE, bus.BTN_VALID, bus.START_GAME} !== {m_code, m_valid, m_start}) begin
            failures++;
            $display("FAIL model t=%0t got code=%0d valid=%0d start=%0d expected code=%0d valid=%0d start=%0d",
                     $time, bus.BTN_CODE, bus.BTN_VALID, bus.START_GAME, m_code, m_valid, m_start);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      int saw;
      bus.BTN_RAW   = 4'b0000;
      bus.START_RAW = 1'b0;
      #1 RST_N = 1'b0;
      step(3);
      check("rst_code",  int'(bus.BTN_CODE),   0);
      check("rst_valid", int'(bus.BTN_VALID),  0);
      check("rst_start", int'(bus.START_GAME), 0);
      RST_N = 1'b1;
      step(3);

      // Short noise pulse on color 0
      bus.BTN_RAW = 4'b0001;
      step(3);
      bus.BTN_RAW = 4'b0000;
      saw = 0;
      repeat (12) begin step(1); if (bus.BTN_VALID) saw = 1; end
      check("noise_valid", saw, 0);
      check("noise_code", int'(bus.BTN_CODE), 0);

      // Two colors at once
      bus.BTN_RAW = 4'b0011;
      saw = 0;
      repeat (20) begin step(1); if (bus.BTN_VALID) saw = 1; end
      check("two_hot_valid", saw, 0);
      bus.BTN_RAW = 4'b0000;
      step(5);

      // Clean press and release of color 2
      bus.BTN_RAW = 4'b0100;
      step(6);
      check("press_e6_valid", int'(bus.BTN_VALID), 0);
      step(1);
      check("press_e7_valid", int'(bus.BTN_VALID), 1);
      check("press_e7_code",  int'(bus.BTN_CODE),  2);
      step(5);
      bus.BTN_RAW = 4'b0000;
      step(6);
      check("rel_e6_valid", int'(bus.BTN_VALID), 1);
      step(1);
      check("rel_e7_valid", int'(bus.BTN_VALID), 0);
      check("rel_code_hold", int'(bus.BTN_CODE), 2);
      step(3);

      // Short release bounce while held
      bus.BTN_RAW = 4'b0100;
      step(7);
      check("bounce_held", int'(bus.BTN_VALID), 1);
      saw = 0;
      bus.BTN_RAW = 4'b0000;
      repeat (2) begin step(1); if (!bus.BTN_VALID) saw = 1; end
      bus.BTN_RAW = 4'b0100;
      repeat (12) begin step(1); if (!bus.BTN_VALID) saw = 1; end
      check("bounce_dropped", saw, 0);
      bus.BTN_RAW = 4'b0000;
      step(10);
      check("bounce_released", int'(bus.BTN_VALID), 0);

      // Hold color 3, add color 0, drop color 3
      bus.BTN_RAW = 4'b1000;
      step(7);
      check("c3_valid", int'(bus.BTN_VALID), 1);
      check("c3_code",  int'(bus.BTN_CODE),  3);
      bus.BTN_RAW = 4'b1001;
      step(5);
      check("c3_extra_code",  int'(bus.BTN_CODE),  3);
      check("c3_extra_valid", int'(bus.BTN_VALID), 1);
      bus.BTN_RAW = 4'b0001;
      step(6);
      check("c3_drop_e6", int'(bus.BTN_VALID), 1);
      step(1);
      check("c3_drop_e7", int'(bus.BTN_VALID), 0);
      check("c3_drop_code", int'(bus.BTN_CODE), 3);
      bus.BTN_RAW = 4'b0000;
      step(10);

      // Simultaneous color and start
      bus.BTN_RAW   = 4'b0010;
      bus.START_RAW = 1'b1;
      step(6);
      check("sim_e6_valid", int'(bus.BTN_VALID),  0);
      check("sim_e6_start", int'(bus.START_GAME), 0);
      step(1);
      check("sim_e7_valid", int'(bus.BTN_VALID),  1);
      check("sim_e7_start", int'(bus.START_GAME), 1);
      check("sim_e7_code",  int'(bus.BTN_CODE),   1);
      step(3);
      bus.BTN_RAW   = 4'b0000;
      bus.START_RAW = 1'b0;
      step(6);
      check("simrel_e6_valid", int'(bus.BTN_VALID),  1);
      check("simrel_e6_start", int'(bus.START_GAME), 1);
      step(1);
      check("simrel_e7_valid", int'(bus.BTN_VALID),  0);
      check("simrel_e7_start", int'(bus.START_GAME), 0);
      step(3);

      // Reset pulse in the middle of a start debounce window
      bus.START_RAW = 1'b1;
      step(3);
      #2 RST_N = 1'b0;
      #1;
      check("mid_rst_start", int'(bus.START_GAME), 0);
      check("mid_rst_code",  int'(bus.BTN_CODE),   0);
      step(2);
      #2 RST_N = 1'b1;
      step(6);
      check("post_rst_e6_start", int'(bus.START_GAME), 0);
      step(1);
      check("post_rst_e7_start", int'(bus.START_GAME), 1);
      bus.START_RAW = 1'b0;
      step(10);
      check("end_start", int'(bus.START_GAME), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
